// File: rtl/clkmgr_clk_en_ctrl.sv
// Staggered clock-family enable controller.
// A change of req_i walks the per-domain enables one bit at a time, either
// upward when enabling or downward when disabling. Consecutive bit changes are
// StaggerCycles+1 cycles apart. The controller then waits for the synchronized
// acknowledges to match the target.
// Optional feature: define CLKMGR_EN_CTRL_TIMEOUT_EN to bound the ack wait to
// TimeoutCycles and raise a sticky err_o when the bound expires.
module clkmgr_clk_en_ctrl #(
    parameter int unsigned NumClocks     = 3,
    parameter int unsigned StaggerCycles = 2,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [NumClocks-1:0] acks_i,
    output logic [NumClocks-1:0] ens_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 err_clr_i
);

    localparam int unsigned IdxW = (NumClocks > 1) ? $clog2(NumClocks) : 1;
    localparam int unsigned CntW = (StaggerCycles > 0) ? $clog2(StaggerCycles + 1) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumClocks - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(StaggerCycles);

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StWaitAck
    } state_e;

    state_e                 state_q, state_d;
    logic                   target_q, target_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NumClocks-1:0]   ens_q, ens_d;
    logic                   done_q, done_d;
    logic [NumClocks-1:0]   acks_meta_q, acks_sync_q;
    logic [IdxW-1:0]        start_idx;
    logic                   last_bit;
    logic                   ack_match;

`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            timeout;
`else
    logic            unused_err_clr;
    logic [31:0]     unused_timeout_cycles;

    assign unused_err_clr        = err_clr_i;
    assign unused_timeout_cycles = TimeoutCycles;
`endif

    // Two-flop synchronizer for the asynchronous acknowledges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acks_meta_q <= '0;
            acks_sync_q <= '0;
        end else begin
            acks_meta_q <= acks_i;
            acks_sync_q <= acks_meta_q;
        end
    end

    // Controller state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            target_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ens_q    <= '0;
            done_q   <= 1'b0;
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ens_q    <= ens_d;
            done_q   <= done_d;
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic: the first bit of a sequence is written on the IDLE->STEP
    // edge, so it is visible during the first STEP cycle
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ens_d     = ens_q;
        done_d    = 1'b0;
        start_idx = req_i ? '0 : LastIdx;
        last_bit  = target_q ? (idx_q == LastIdx) : (idx_q == '0);
        ack_match = (acks_sync_q == {NumClocks{target_q}});
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (req_i != target_q) begin
                    target_d         = req_i;
                    idx_d            = start_idx;
                    cnt_d            = '0;
                    ens_d[start_idx] = req_i;
                    state_d          = StStep;
                end
            end
            StStep: begin
                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    if (last_bit) begin
                        state_d = StWaitAck;
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        idx_d        = target_q ? (idx_q + 1'b1) : (idx_q - 1'b1);
                        ens_d[idx_d] = target_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitAck: begin
                if (ack_match) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
                else if (tmo_q == TmoMax) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
        // A timeout in the same cycle as a clear keeps the flag set
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
`endif
    end

    assign ens_o  = ens_q;
    assign done_o = done_q;
    assign busy_o = (state_q != StIdle);
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
    assign err_o  = err_q;
`else
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_clkmgr_clk_en_ctrl.sv
// Bench for clkmgr_clk_en_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a timeline model.
module tb_clkmgr_clk_en_ctrl;

    localparam int unsigned N = 3;
    localparam int unsigned S = 2;
    localparam int unsigned T = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_i;
    logic [N-1:0] acks_i;
    logic [N-1:0] ens_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic         err_clr_i;

    int total = 0;
    int bad   = 0;

    // Model: a transition is an "age" n counted in edges since it began; bit k
    // of the walk order has switched once n >= k*(S+1), ack wait starts at n = N*(S+1)
    bit           m_act, m_tgt, m_done, m_err;
    int           m_n;
    logic [N-1:0] m_ens, m_s1, m_s2;

    clkmgr_clk_en_ctrl #(
        .NumClocks    (N),
        .StaggerCycles(S),
        .TimeoutCycles(T)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .acks_i   (acks_i),
        .ens_o    (ens_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_act  = 0; m_tgt = 0; m_done = 0; m_err = 0; m_n = 0;
        m_ens  = '0; m_s1 = '0; m_s2 = '0;
    endfunction

    function automatic void model_step();
        bit set_err;
        int unsigned switched;
        int unsigned pos;
        set_err = 0;
        m_done  = 0;
        if (!m_act) begin
            if (req_i != m_tgt) begin
                m_tgt = req_i;
                m_act = 1;
                m_n   = 0;
            end
        end else if (m_n < int'(N * (S + 1))) begin
            m_n++;
        end else begin
            if (m_s2 == {N{m_tgt}}) begin
                m_done = 1;
                m_act  = 0;
            end
`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
            else if (m_n - int'(N * (S + 1)) == int'(T) - 1) begin
                set_err = 1;
                m_act   = 0;
            end
`endif
            else begin
                m_n++;
            end
        end
        if (set_err) m_err = 1;
        else if (err_clr_i) m_err = 0;
        switched = N;
        if (m_act) begin
            switched = unsigned'(m_n) / (S + 1) + 1;
            if (switched > N) switched = N;
        end
        for (int unsigned k = 0; k < N; k++) begin
            pos = m_tgt ? k : (N - 1 - k);
            m_ens[pos] = (k < switched) ? m_tgt : !m_tgt;
        end
        m_s2 = m_s1;
        m_s1 = acks_i;
    endfunction

    // Reference model advances on every active edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1) begin
                chk("m_ens",  32'(ens_o),  32'(m_ens));
                chk("m_busy", 32'(busy_o), 32'(m_act));
                chk("m_done", 32'(done_o), 32'(m_done));
                chk("m_err",  32'(err_o),  32'(m_err));
            end
        end
    end

    task automatic wait_done(input int budget, output int seen, output int cyc);
        seen = 0;
        cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            cyc = i + 1;
            if (done_o === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    initial begin
        int seen, cyc, dcnt;
        rst_ni = 1'b0; req_i = 1'b0; acks_i = '0; err_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ens", 32'(ens_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Enable walk: LSB first, 3 cycles apart
        req_i = 1'b1;
        @(negedge clk_i);
        chk("en_1", 32'(ens_o), 32'b001);
        chk("en_busy", 32'(busy_o), 1);
        repeat (3) @(negedge clk_i);
        chk("en_2", 32'(ens_o), 32'b011);
        repeat (3) @(negedge clk_i);
        chk("en_3", 32'(ens_o), 32'b111);
        acks_i = 3'b111;
        wait_done(20, seen, cyc);
        chk("en_done", 32'(seen), 1);
        chk("en_done_lat", 32'(cyc), 4);
        chk("en_idle", 32'(busy_o), 0);
        @(negedge clk_i);
        chk("en_done_pulse", 32'(done_o), 0);

        // Disable walk: MSB first
        req_i = 1'b0;
        @(negedge clk_i);
        chk("dis_1", 32'(ens_o), 32'b011);
        repeat (3) @(negedge clk_i);
        chk("dis_2", 32'(ens_o), 32'b001);
        repeat (3) @(negedge clk_i);
        chk("dis_3", 32'(ens_o), 32'b000);
        acks_i = 3'b000;
        wait_done(20, seen, cyc);
        chk("dis_done", 32'(seen), 1);

`ifdef CLKMGR_EN_CTRL_TIMEOUT_EN
        // Acks never arrive: timeout 16 cycles after entering the wait
        req_i = 1'b1;
        repeat (7) @(negedge clk_i);
        chk("tmo_ens", 32'(ens_o), 32'b111);
        seen = 0; cyc = 0; dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dcnt++;
            if (err_o === 1'b1) begin
                seen = 1;
                cyc  = i + 1;
                break;
            end
        end
        chk("tmo_seen", 32'(seen), 1);
        chk("tmo_lat", 32'(cyc), 19);
        chk("tmo_nodone", 32'(dcnt), 0);
        chk("tmo_ens_hold", 32'(ens_o), 32'b111);
        chk("tmo_idle", 32'(busy_o), 0);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("tmo_clr", 32'(err_o), 0);
`else
        // Acks never arrive: the wait is unbounded and no error is raised
        req_i = 1'b1;
        repeat (1000) @(negedge clk_i);
        chk("hang_busy", 32'(busy_o), 1);
        chk("hang_err", 32'(err_o), 0);
        acks_i = 3'b111;
        wait_done(20, seen, cyc);
        chk("hang_done", 32'(seen), 1);
`endif

        // Back to all-off
        req_i  = 1'b0;
        acks_i = 3'b000;
        wait_done(60, seen, cyc);
        chk("off_done", 32'(seen), 1);

        // Request drops mid-walk: enable completes, then disable follows
        req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        req_i  = 1'b0;
        acks_i = 3'b111;
        wait_done(60, seen, cyc);
        chk("tog_done", 32'(seen), 1);
        chk("tog_ens", 32'(ens_o), 32'b111);
        @(negedge clk_i);
        chk("tog_dis", 32'(ens_o), 32'b011);
        acks_i = 3'b000;
        wait_done(60, seen, cyc);
        chk("tog_off", 32'(ens_o), 32'b000);

        // Asynchronous reset in the middle of a walk
        req_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("ar_pre", 32'(ens_o), 32'b011);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_ens", 32'(ens_o), 0);
        chk("ar_busy", 32'(busy_o), 0);
        chk("ar_done", 32'(done_o), 0);
        chk("ar_err", 32'(err_o), 0);
        req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dcnt++;
        end
        chk("ar_nodone", 32'(dcnt), 0);

        // Randomized traffic; acks follow the enables with random lag
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_i);
            if ($urandom_range(19) == 0) req_i = ~req_i;
            for (int b = 0; b < int'(N); b++) begin
                if ($urandom_range(1) == 1) acks_i[b] = ens_o[b];
            end
            err_clr_i = ($urandom_range(7) == 0);
        end
        err_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkmgr_clk_en_ctrl.md
CLKMGR_CLK_EN_CTRL -- requirements
Module: clkmgr_clk_en_ctrl

Interface
REQ-001 Parameter NumClocks, default 3, number of controlled clock domains (>=1).
REQ-002 Parameter StaggerCycles, default 2, idle clk_i cycles between consecutive enable-bit changes (>=0).
REQ-003 Parameter TimeoutCycles, default 16, max clk_i cycles allowed in WAIT_ACK (>=1).
REQ-004 clk_i  input  1  controller clock.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  1  requested family state: 1 = all clocks on, 0 = all off; synchronous to clk_i.
REQ-007 acks_i  input  NumClocks  per-domain enable acknowledge; asynchronous to clk_i.
REQ-008 ens_o  output  NumClocks  registered per-domain enable requests.
REQ-009 busy_o  output  1  high while the state is not IDLE.
REQ-010 done_o  output  1  one-cycle pulse when a transition completes.
REQ-011 err_o  output  1  sticky ack-timeout flag.
REQ-012 err_clr_i  input  1  synchronous clear of err_o.

Function
REQ-013 acks_i shall pass through a 2-flop synchronizer (acks_sync) before any use.
REQ-014 States: IDLE, STEP, WAIT_ACK.
REQ-015 IDLE: if req_i != target_q, latch target_q <= req_i, load idx (0 when enabling, NumClocks-1 when disabling), go to STEP; else remain.
REQ-016 req_i shall be sampled only in IDLE; changes during STEP/WAIT_ACK are acted on after return to IDLE.
REQ-017 STEP: ens_o[idx] <= target_q on the first STEP cycle, then wait StaggerCycles cycles; then either advance idx (up when enabling, down when disabling) or, after the last bit, go to WAIT_ACK.
REQ-018 Consecutive ens_o bit changes shall be exactly StaggerCycles+1 cycles apart; the first change is visible one cycle after req_i is sampled in IDLE.
REQ-019 WAIT_ACK: when acks_sync == {NumClocks{target_q}}, assert done_o for exactly one cycle and go to IDLE.
REQ-020 Ack match is evaluated only in WAIT_ACK; early acks during STEP are ignored.
REQ-021 busy_o shall be combinationally (state != IDLE).
REQ-022 err_clr_i and a simultaneous timeout in the same cycle: set wins.

Reset
REQ-023 On rst_ni low: state IDLE, target_q 0, ens_o all 0, idx 0, counters 0, synchronizer flops 0, done_o 0, err_o 0, busy_o 0.
REQ-024 Reset asserted mid-operation shall abort immediately to reset values, with no done_o pulse.

Configuration
REQ-025 Macro CLKMGR_EN_CTRL_TIMEOUT_EN defined: a counter runs in WAIT_ACK; when it reaches TimeoutCycles without an ack match, set err_o, leave ens_o at target, go to IDLE with no done_o; counter clears on WAIT_ACK entry.
REQ-026 Macro not defined: no timeout counter; WAIT_ACK waits indefinitely; err_o tied 0; err_clr_i unused.

Verification (NumClocks=3, StaggerCycles=2, TimeoutCycles=16)
REQ-027 req_i 0->1, acks follow ens_o -> ens_o goes 001, 011, 111 at 3-cycle spacing; done_o pulses once; busy_o then low.
REQ-028 From 111, req_i 1->0 -> ens_o goes 011, 001, 000 (MSB first); done_o once acks_sync==000.
REQ-029 With TIMEOUT_EN, acks_i held 000 after enable -> err_o high 16 cycles after WAIT_ACK entry; no done_o; ens_o stays 111; err_clr_i clears it.
REQ-030 req_i toggles 1->0 during STEP -> enable sequence completes to 111 with done_o, then disable sequence starts from IDLE.
REQ-031 rst_ni asserted with ens_o=011 in STEP -> all outputs 0 asynchronously; no done_o after release.
REQ-032 Without TIMEOUT_EN, acks held 000 for 1000 cycles -> busy_o stays high, err_o stays 0.
